// File: rtl/burst_incre_gen.sv
// burst_incre_gen: on an accepted Trigger this block emits repeated bursts of a
// linear ramp (Start + k*Step, wrapping) separated by programmable idle gaps.
// Every output is registered. Valid/Busy/Done are side-band flags for the
// controller, which re-aligns them with the downstream delay line.
module burst_incre_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Trigger,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Start_Val,
    input  logic [WIDTH-1:0] Step,
    input  logic [CNT_W-1:0] Burst_Len,
    input  logic [CNT_W-1:0] Gap_Len,
    input  logic [CNT_W-1:0] Burst_Num,
    input  logic [WIDTH-1:0] Idle_Val,
    output logic [WIDTH-1:0] Dout,
    output logic             Valid,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_reg, state_next;

    // Parameters captured on an accepted Trigger
    logic [WIDTH-1:0] start_reg, start_next;
    logic [WIDTH-1:0] step_reg,  step_next;
    logic [CNT_W-1:0] len_reg,   len_next;
    logic [CNT_W-1:0] gap_reg,   gap_next;
    logic [CNT_W-1:0] num_reg,   num_next;

    // Ramp accumulator and counters
    logic [WIDTH-1:0] acc_reg,        acc_next;
    logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;
    logic [CNT_W-1:0] gap_cnt_reg,    gap_cnt_next;
    logic [CNT_W-1:0] burst_cnt_reg,  burst_cnt_next;

    // Registered outputs. done_pend_reg marks the cycle after the final sample so
    // that Done lands one cycle after the last Valid and retrigger waits for it.
    logic [WIDTH-1:0] dout_reg,  dout_next;
    logic             valid_reg, valid_next;
    logic             busy_reg,  busy_next;
    logic             done_reg,  done_next;
    logic             done_pend_reg, done_pend_next;

    logic             accept;
    logic             last_sample;
    logic             last_burst;
    logic             gap_end;
    logic [CNT_W-1:0] burst_inc;

    // Trigger qualification and end-of-burst/gap decode
    always_comb begin
        accept      = (state_reg == ST_IDLE) && Trigger && !Abort &&
                      (Burst_Len != '0) && !done_pend_reg;
        last_sample = (sample_cnt_reg == (len_reg - CNT_ONE));
        burst_inc   = burst_cnt_reg + CNT_ONE;
        // Burst_Num = 0 is continuous: the burst counter simply wraps.
        last_burst  = (num_reg != '0) && (burst_inc == num_reg);
        gap_end     = (gap_cnt_reg == (gap_reg - CNT_ONE));
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; Abort outranks every other transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (last_sample) begin
                    if (last_burst) begin
                        state_next = ST_IDLE;
                    end else if (gap_reg != '0) begin
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_GAP: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (gap_end) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        start_next      = start_reg;
        step_next       = step_reg;
        len_next        = len_reg;
        gap_next        = gap_reg;
        num_next        = num_reg;
        acc_next        = acc_reg;
        sample_cnt_next = sample_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        burst_cnt_next  = burst_cnt_reg;
        dout_next       = Idle_Val;
        valid_next      = 1'b0;
        busy_next       = 1'b0;
        done_next       = done_pend_reg;
        done_pend_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    start_next      = Start_Val;
                    step_next       = Step;
                    len_next        = Burst_Len;
                    gap_next        = Gap_Len;
                    num_next        = Burst_Num;
                    acc_next        = Start_Val;
                    sample_cnt_next = '0;
                    gap_cnt_next    = '0;
                    burst_cnt_next  = '0;
                end
            end
            ST_RUN: begin
                if (!Abort) begin
                    dout_next  = acc_reg;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    if (last_sample) begin
                        burst_cnt_next  = burst_inc;
                        sample_cnt_next = '0;
                        gap_cnt_next    = '0;
                        acc_next        = start_reg;
                        done_pend_next  = last_burst;
                    end else begin
                        acc_next        = acc_reg + step_reg;
                        sample_cnt_next = sample_cnt_reg + CNT_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (!Abort) begin
                    busy_next    = 1'b1;
                    gap_cnt_next = gap_cnt_reg + CNT_ONE;
                    if (gap_end) begin
                        acc_next        = start_reg;
                        sample_cnt_next = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath, parameter and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            start_reg      <= '0;
            step_reg       <= '0;
            len_reg        <= '0;
            gap_reg        <= '0;
            num_reg        <= '0;
            acc_reg        <= '0;
            sample_cnt_reg <= '0;
            gap_cnt_reg    <= '0;
            burst_cnt_reg  <= '0;
            dout_reg       <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            done_pend_reg  <= 1'b0;
        end else begin
            start_reg      <= start_next;
            step_reg       <= step_next;
            len_reg        <= len_next;
            gap_reg        <= gap_next;
            num_reg        <= num_next;
            acc_reg        <= acc_next;
            sample_cnt_reg <= sample_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            burst_cnt_reg  <= burst_cnt_next;
            dout_reg       <= dout_next;
            valid_reg      <= valid_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            done_pend_reg  <= done_pend_next;
        end
    end

    assign Dout  = dout_reg;
    assign Valid = valid_reg;
    assign Busy  = busy_reg;
    assign Done  = done_reg;

endmodule

// File: doc/burst_incre_gen.md
# burst_incre_gen

Burst increment generator for the AFG vertical data path. On a trigger it emits bursts of a linear ramp, Start + k·Step modulo 2^WIDTH, k = 0..Burst_Len-1. Bursts are separated by programmable idle gaps and repeated a programmable number of times. Dout feeds the 4-stage 16-bit burst-increment delay line directly downstream, which adds a fixed 4-cycle latency. Valid/Busy/Done are side-band signals for the controller, which delays them to match that path.

## Interface
Parameters:
- WIDTH, 16, sample width of Start_Val/Step/Idle_Val/Dout
- CNT_W, 16, width of Burst_Len, Gap_Len, Burst_Num and their internal counters

Ports:
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Trigger  in  1  start request, sampled only in IDLE
- Abort  in  1  synchronous stop; priority over Trigger
- Start_Val  in  WIDTH  first sample of each burst, latched on accepted Trigger
- Step  in  WIDTH  per-sample increment (two's-complement wrap), latched on Trigger
- Burst_Len  in  CNT_W  samples per burst, latched on Trigger; 0 = Trigger ignored
- Gap_Len  in  CNT_W  idle cycles between bursts, latched on Trigger
- Burst_Num  in  CNT_W  bursts per trigger, latched on Trigger; 0 = continuous until Abort
- Idle_Val  in  WIDTH  level driven when not in a burst
- Dout  out  WIDTH  registered sample to downstream delay line
- Valid  out  1  high while Dout carries a burst sample
- Busy  out  1  high in RUN or GAP
- Done  out  1  one-cycle pulse on natural completion

## Operation
- Reset values: Dout=0, Valid=0, Busy=0, Done=0. State=IDLE. All counters and latched parameters are 0.
- States: IDLE, RUN, GAP.
- IDLE -> RUN: Trigger=1, Abort=0, Burst_Len!=0. Latch all parameters, set acc=Start_Val, sample_cnt=0, burst_cnt=0.
- RUN: Dout<=acc, Valid<=1, acc<=acc+Step (WIDTH-bit, carry discarded), sample_cnt++.
  - After the sample with sample_cnt=Burst_Len-1, burst_cnt++.
  - If burst_cnt+1 = Burst_Num (Burst_Num!=0): go to IDLE and pulse Done.
  - Else if Gap_Len=0: stay in RUN, reload acc=Start_Val, sample_cnt=0.
  - Else: go to GAP.
- GAP: Dout<=Idle_Val, Valid<=0, Busy=1. Count Gap_Len cycles, then go to RUN with acc reloaded to Start_Val.
- IDLE: Dout<=Idle_Val (one-cycle registered lag), Valid=0.
- Abort in RUN/GAP: go to IDLE on the next edge. Dout<=Idle_Val, Valid=0, Done is not pulsed. Abort in IDLE blocks Trigger.
- Trigger in RUN/GAP is ignored; parameter input changes there have no effect until the next accepted Trigger.
- Reset asserted mid-burst: reset values take effect on the next edge, overriding Abort and Trigger.
- Burst_Num counter is CNT_W bits. In continuous mode it does not saturate or stop at wrap.

## Timing
- Trigger accepted at edge T. Sample k appears on Dout/Valid in the cycle after edge T+1+k. First-sample latency is 1 cycle.
- A burst occupies exactly Burst_Len consecutive Valid cycles. A gap occupies exactly Gap_Len cycles with Valid=0.
- Busy rises with the first Valid cycle. Busy falls in the same cycle Done is high.
- Done is high for one cycle, immediately after the last Valid cycle.
- The earliest retrigger is accepted on the edge that ends the Done cycle, giving one Idle_Val cycle between triggered sequences.
- Downstream the sample appears 4 cycles later. The controller delays Valid/Done by 4 to match.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Single burst: Start=0x0010, Step=0x0003, Burst_Len=4, Gap=0, Num=1, Idle=0xAAAA. Required Dout: 0010, 0013, 0016, 0019 with Valid=1, then 0xAAAA with Done=1 for one cycle and Busy=0.
- Wrap and negative step: Start=0xFFFE, Step=0x0001, Len=4 -> FFFE, FFFF, 0000, 0001. Start=0x0001, Step=0xFFFF, Len=3 -> 0001, 0000, FFFF.
- Repeat with gap: Start=5, Step=1, Len=2, Gap=3, Num=3 -> 5, 6, then 3×Idle with Valid=0, then 5, 6, then 3×Idle, then 5, 6, then Done. Busy is continuous for 12 cycles.
- Back-to-back and continuous mode: Gap=0, Num=0, Len=3, Start=0, Step=2 -> 0, 2, 4, 0, 2, 4, … with Valid held high. Abort mid-sequence -> next cycle Valid=0, Dout=Idle, Done never asserted.
- Edge cases:
  - Burst_Len=0 with Trigger -> stays IDLE, Busy=0.
  - Trigger during RUN -> ignored, sequence unchanged.
  - Trigger and Abort together in IDLE -> no start.
  - Reset asserted during GAP -> next cycle all outputs at reset values. A subsequent Trigger then starts cleanly from Start_Val.
